phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Generates the 3-bit `phase` that the instruction control decoder consumes and sequences the processor through the six-phase instruction cycle. It supports run, stop, single-step and halt, and stalls the phase counter while memory is not ready. It sits between the front-panel/debug inputs, the memory subsystem and the control decoder, and counts retired instructions.

## Interface
- `NUM_PHASES`, 6, phases per instruction (0..5); fixed, not for reconfiguration
- `ICNT_W`, 16, width of retired-instruction counter
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse: begin execution from IDLE or WAIT_STEP
- `stop`  in  1  one-cycle pulse: request stop at next instruction boundary
- `step_mode`  in  1  level: 1 = stop after every instruction
- `mem_ready`  in  1  level: memory access complete; sampled in phases 1 and 4
- `instruction`  in  16  current IR contents, stable from phase 2 to phase 5
- `phase`  out  3  current phase to control decoder
- `running`  out  1  state == RUN
- `halted`  out  1  state == HALT
- `step_wait`  out  1  state == WAIT_STEP
- `inst_done`  out  1  one-cycle pulse in the final phase-5 cycle of each instruction
- `icount`  out  ICNT_W  retired-instruction count

## Operation
- Phases: 0 boundary/bubble, 1 fetch, 2 decode/register read, 3 ALU, 4 memory, 5 writeback.
- States: IDLE, RUN, WAIT_STEP, HALT. Outside RUN, `phase` = 0.
- **IDLE** + `start` → RUN. `start` and `stop` in the same cycle: `stop` wins, stay IDLE.
- **RUN**:
  - `phase` advances 0→1→2→3→4→5 one per clock.
  - In phase 1 or 4 with `mem_ready` = 0, `phase` holds; it advances on the first cycle `mem_ready` = 1.
  - Leaving phase 5 (phase 5 is never stalled): assert `inst_done` and increment `icount` (wraps modulo 2^ICNT_W).
  - Next state, in priority order:
    - HLT (`instruction[15:14]` = 2'b11 and `instruction[7:4]` = 4'b1111) → HALT
    - `stop_pending` → IDLE, clear `stop_pending`
    - `step_mode` = 1 → WAIT_STEP
    - otherwise `phase` → 0, stay RUN
- **stop**: a pulse in any state sets `stop_pending`. `stop_pending` is cleared on any entry to IDLE or HALT and by `rst`. It never truncates an instruction.
- **WAIT_STEP** + `start` → RUN for exactly one instruction if `step_mode` is still 1; otherwise → RUN and continue. WAIT_STEP with `stop_pending` set → IDLE next cycle.
- **HALT** is sticky: `start` and `stop` are ignored; only `rst` exits.
- HLT instructions are counted in `icount`.

## Timing
- Reset values: state IDLE, `phase` 0, `running` 0, `halted` 0, `step_wait` 0, `inst_done` 0, `icount` 0, `stop_pending` 0.
- `rst` mid-instruction: all reset values on the next edge; no further `inst_done`.
- All outputs are registered, except `inst_done`, which is a combinational decode of (RUN ∧ `phase` = 5).
- `start` accepted at edge N: `running` = 1 and `phase` = 0 at N+1; `phase` = 1 at N+2.
- Unstalled instruction: 6 cycles (phase 0..5). Each `mem_ready` = 0 cycle in phase 1 or 4 adds one cycle.
- `icount` updates one cycle after `inst_done`.
- The state change out of RUN happens at the edge ending phase 5. `halted`, `step_wait` or IDLE is visible the next cycle with `phase` = 0.
- `instruction` is sampled only in the phase-5 cycle.

## Structure
- Shared package `cpu_pkg`:
  - phase constants `PH_BOUND`, `PH_FETCH`, `PH_DEC`, `PH_ALU`, `PH_MEM`, `PH_WB`
  - sequencer state enum
  - opcode constants `OP_ALU` = 2'b11, `ALU_HLT` = 4'b1111; the control decoder also uses these
- Single module; no sub-module. The phase counter, FSM and `icount` are small enough to stay flat.

## Test plan
- Reset, then `start` at cycle 0 with `mem_ready` = 1 and a non-HLT instruction: `phase` 0,1,2,3,4,5,0,... from cycle 1; `inst_done` every 6 cycles; `icount` = 3 after 18 cycles.
- `mem_ready` = 0 for 3 cycles in phase 1 and 2 cycles in phase 4: `phase` holds at 1 for 4 cycles and at 4 for 3 cycles; instruction length 11 cycles.
- `step_mode` = 1, `start`: one instruction, then `step_wait` = 1 with `phase` = 0. Each subsequent `start` pulse adds exactly one to `icount`.
- `stop` pulse during phase 2: the instruction completes, `icount` +1, then IDLE. Simultaneous `start` and `stop` in IDLE: stays IDLE.
- Instruction 16'hC0F0 reaches phase 5: `halted` = 1 next cycle, `icount` +1, `start` ignored; `rst` returns all outputs to 0.
- `ICNT_W` = 4, run 17 instructions: `icount` wraps to 1. `rst` asserted in phase 3: `phase` = 0 and `running` = 0 on the next edge, with no `inst_done`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-cycle phase encoding, sequencer states
// and the opcode fields that the sequencer and control decoder both look at.
package cpu_pkg;

    localparam logic [2:0] PH_BOUND = 3'd0;
    localparam logic [2:0] PH_FETCH = 3'd1;
    localparam logic [2:0] PH_DEC   = 3'd2;
    localparam logic [2:0] PH_ALU   = 3'd3;
    localparam logic [2:0] PH_MEM   = 3'd4;
    localparam logic [2:0] PH_WB    = 3'd5;

    localparam logic [1:0] OP_ALU  = 2'b11;
    localparam logic [3:0] ALU_HLT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_STEP = 2'd2,
        ST_HALT      = 2'd3
    } seq_state_t;

    // HLT is the ALU-class opcode with the all-ones function field.
    function automatic logic is_hlt(input logic [15:0] ir);
        return (ir[15:14] == OP_ALU) && (ir[7:4] == ALU_HLT);
    endfunction

endpackage

// File: rtl/phase_sequencer.sv
// Six-phase instruction-cycle sequencer with run/stop/single-step/halt control,
// memory-ready stalls in fetch and memory phases, and a retired-instruction count.
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_PHASES = 6,
    parameter int ICNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              step_mode,
    input  logic              mem_ready,
    input  logic [15:0]       instruction,
    output logic [2:0]        phase,
    output logic              running,
    output logic              halted,
    output logic              step_wait,
    output logic              inst_done,
    output logic [ICNT_W-1:0] icount
);

    localparam logic [2:0] PH_LAST = 3'(NUM_PHASES - 1);

    seq_state_t        state, state_nxt;
    logic [2:0]        phase_nxt;
    logic              stop_pending, stop_pending_nxt;
    logic [ICNT_W-1:0] icount_nxt;
    logic              stall;

    assign stall     = ((phase == PH_FETCH) || (phase == PH_MEM)) && !mem_ready;
    assign inst_done = (state == ST_RUN) && (phase == PH_LAST);

    always_comb begin
        state_nxt        = state;
        phase_nxt        = phase;
        stop_pending_nxt = stop_pending | stop;
        icount_nxt       = icount;

        unique case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                    phase_nxt = PH_BOUND;
                end
            end
            ST_RUN: begin
                if (phase == PH_LAST) begin
                    icount_nxt = icount + ICNT_W'(1);
                    phase_nxt  = PH_BOUND;
                    if (is_hlt(instruction))
                        state_nxt = ST_HALT;
                    else if (stop_pending || stop)
                        state_nxt = ST_IDLE;
                    else if (step_mode)
                        state_nxt = ST_WAIT_STEP;
                end else if (!stall) begin
                    phase_nxt = phase + 3'd1;
                end
            end
            ST_WAIT_STEP: begin
                if (stop_pending)
                    state_nxt = ST_IDLE;
                else if (start && !stop)
                    state_nxt = ST_RUN;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = PH_BOUND;
            end
        endcase

        // Residing in IDLE or HALT counts as entry, so a stop seen there never
        // leaks into the next run.
        if ((state_nxt == ST_IDLE) || (state_nxt == ST_HALT))
            stop_pending_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            phase        <= PH_BOUND;
            stop_pending <= 1'b0;
            icount       <= '0;
            running      <= 1'b0;
            halted       <= 1'b0;
            step_wait    <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase        <= phase_nxt;
            stop_pending <= stop_pending_nxt;
            icount       <= icount_nxt;
            running      <= (state_nxt == ST_RUN);
            halted       <= (state_nxt == ST_HALT);
            step_wait    <= (state_nxt == ST_WAIT_STEP);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer, built with a 4-bit instruction counter so
// the wrap case is reachable quickly.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stop, step_mode, mem_ready;
    logic [15:0] instruction;
    logic [2:0]  phase;
    logic        running, halted, step_wait, inst_done;
    logic [3:0]  icount;

    int vectors    = 0;
    int miscompares = 0;

    phase_sequencer #(.NUM_PHASES(6), .ICNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .step_mode(step_mode), .mem_ready(mem_ready), .instruction(instruction),
        .phase(phase), .running(running), .halted(halted), .step_wait(step_wait),
        .inst_done(inst_done), .icount(icount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [3:0] exp_icount);
        check({tag, "_phase"}, 32'(phase), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_step_wait"}, 32'(step_wait), 32'd0);
        check({tag, "_inst_done"}, 32'(inst_done), 32'd0);
        check({tag, "_icount"}, 32'(icount), 32'(exp_icount));
    endtask

    logic [2:0] stall_phase [11] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5};
    logic       stall_ready [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; step_mode = 1'b0;
        mem_ready = 1'b1; instruction = 16'h1234;
        tick(); tick();
        rst = 1'b0;
        check_idle_outputs("reset", 4'd0);

        // Free run: three unstalled instructions.
        start = 1'b1; tick(); start = 1'b0;
        check("run_running", 32'(running), 32'd1);
        for (int i = 0; i < 18; i++) begin
            check("run_phase", 32'(phase), 32'(i % 6));
            check("run_inst_done", 32'(inst_done), 32'((i % 6) == 5));
            tick();
        end
        check("run_icount", 32'(icount), 32'd3);

        // Stalls: 3 cycles in fetch, 2 in memory -> 11-cycle instruction.
        for (int i = 0; i < 11; i++) begin
            mem_ready = stall_ready[i];
            check("stall_phase", 32'(phase), 32'(stall_phase[i]));
            check("stall_inst_done", 32'(inst_done), 32'(i == 10));
            tick();
        end
        mem_ready = 1'b1;
        check("stall_icount", 32'(icount), 32'd4);
        check("stall_phase_wrap", 32'(phase), 32'd0);

        // Single-step.
        step_mode = 1'b1;
        repeat (6) tick();
        check("step_wait", 32'(step_wait), 32'd1);
        check("step_running", 32'(running), 32'd0);
        check("step_phase", 32'(phase), 32'd0);
        check("step_icount", 32'(icount), 32'd5);
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; tick(); start = 1'b0;
            check("step_go_running", 32'(running), 32'd1);
            repeat (6) tick();
            check("step_again_wait", 32'(step_wait), 32'd1);
            check("step_again_icount", 32'(icount), 32'(6 + k));
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check("ws_stop_pending", 32'(step_wait), 32'd1);
        tick();
        check_idle_outputs("ws_stop_idle", 4'd7);

        // Stop request during decode completes the instruction.
        step_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("stop_at_dec", 32'(phase), 32'd2);
        stop = 1'b1; tick(); stop = 1'b0;
        tick(); tick();
        check("stop_ph5", 32'(phase), 32'd5);
        check("stop_ph5_done", 32'(inst_done), 32'd1);
        tick();
        check_idle_outputs("stop_idle", 4'd8);

        // start and stop together: stop wins.
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("startstop_running", 32'(running), 32'd0);
        tick();
        check("startstop_running2", 32'(running), 32'd0);

        // HLT.
        instruction = 16'hC0F0;
        start = 1'b1; tick(); start = 1'b0;
        check("hlt_running", 32'(running), 32'd1);
        repeat (5) tick();
        check("hlt_ph5_done", 32'(inst_done), 32'd1);
        tick();
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_running_off", 32'(running), 32'd0);
        check("hlt_phase", 32'(phase), 32'd0);
        check("hlt_icount", 32'(icount), 32'd9);
        start = 1'b1; tick(); start = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        check("hlt_sticky", 32'(halted), 32'd1);
        check("hlt_sticky_run", 32'(running), 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle_outputs("hlt_reset", 4'd0);

        // 17 instructions wrap the 4-bit counter to 1.
        instruction = 16'hC0E0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (17 * 6) tick();
        check("wrap_icount", 32'(icount), 32'd1);
        check("wrap_running", 32'(running), 32'd1);

        // Reset in the ALU phase.
        repeat (3) tick();
        check("rst_at_alu", 32'(phase), 32'd3);
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle_outputs("mid_reset", 4'd0);
        repeat (6) begin
            tick();
            check("post_reset_no_done", 32'(inst_done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
